// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter for the RV32I register file: N_REQ producers share one write port,
// plus a per-register busy scoreboard for RAW hazard detection at issue.

module rf_wb_sb_cell (
    input  logic clk,
    input  logic rst,
    input  logic set,
    input  logic clr,
    output logic busy
);
    // A new reservation outranks a commit landing on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      busy <= 1'b0;
        else if (set) busy <= 1'b1;
        else if (clr) busy <= 1'b0;
    end
endmodule

module rf_wb_arbiter #(
    parameter int N_REQ = 3,
    parameter bit RR_EN = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req_valid,
    output logic [N_REQ-1:0]     req_ready,
    input  logic [5*N_REQ-1:0]   req_rd,
    input  logic [32*N_REQ-1:0]  req_data,
    input  logic                 alloc_valid,
    input  logic [4:0]           alloc_rd,
    output logic [31:0]          sb_busy,
    output logic                 cu_rdwrite,
    output logic [4:0]           rd_addr,
    output logic [31:0]          rd_in,
    output logic [1:0]           grant_id
);
    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_req_t;

    wb_req_t [N_REQ-1:0] reqs;
    wb_req_t             sel;
    logic [1:0]          ptr, ptr_nxt, start, gnt_idx;
    logic [2:0]          sum, idx;
    logic                any;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign reqs[i].rd   = req_rd[5*i +: 5];
        assign reqs[i].data = req_data[32*i +: 32];
    end

    assign start = RR_EN ? ptr : 2'd0;

    // First valid index at or above the start point, wrapping modulo N_REQ.
    always_comb begin
        req_ready = '0;
        gnt_idx   = '0;
        ptr_nxt   = ptr;
        sel       = '0;
        any       = 1'b0;
        sum       = '0;
        idx       = '0;
        for (int k = 0; k < N_REQ; k++) begin
            sum = {1'b0, start} + 3'(k);
            idx = (sum >= 3'(N_REQ)) ? sum - 3'(N_REQ) : sum;
            if (!any && req_valid[idx]) begin
                any            = 1'b1;
                req_ready[idx] = 1'b1;
                gnt_idx        = idx[1:0];
                sel            = reqs[idx];
                ptr_nxt        = (idx == 3'(N_REQ - 1)) ? 2'd0 : idx[1:0] + 2'd1;
            end
        end
    end

    // Output stage: address/data hold when idle, write enable is a one-cycle pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cu_rdwrite <= 1'b0;
            rd_addr    <= '0;
            rd_in      <= '0;
            grant_id   <= '0;
            ptr        <= '0;
        end else begin
            cu_rdwrite <= any && (sel.rd != 5'd0);
            if (any) begin
                rd_addr  <= sel.rd;
                rd_in    <= sel.data;
                grant_id <= gnt_idx;
                ptr      <= ptr_nxt;
            end
        end
    end

    assign sb_busy[0] = 1'b0;

    // Clearing on cu_rdwrite means busy drops on the same edge the register file commits.
    for (genvar r = 1; r < 32; r++) begin : g_sb
        rf_wb_sb_cell u_cell (
            .clk  (clk),
            .rst  (rst),
            .set  (alloc_valid && (alloc_rd == 5'(r))),
            .clr  (cu_rdwrite && (rd_addr == 5'(r))),
            .busy (sb_busy[r])
        );
    end
endmodule
